// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared constants for the VGA pixel path (colours, screen defaults,
//           push-button indices, move encoding).
// Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } move_e;

endpackage

`default_nettype wire

// File: rtl/btn_tick_debounce.sv
// ============================================================================
// btn_tick_debounce : clock-enable tick generator plus 2-FF button synchroniser
//                     and two-tick sampler (btn needs two consecutive ticks).
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_tick_debounce #(
  parameter int TICK_FAST = 250000,
  parameter int TICK_SLOW = 1000000,
  parameter int NBTN      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            switch,
  input  logic [NBTN-1:0] push,
  output logic            tick,
  output logic [NBTN-1:0] btn
);

  localparam int CNT_MAX = (TICK_FAST > TICK_SLOW) ? TICK_FAST : TICK_SLOW;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(TICK_FAST - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(TICK_SLOW - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, lim_m1;
  logic [NBTN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NBTN-1:0]  q1_q, q1_d, q2_q, q2_d;

  always_comb begin
    lim_m1  = switch ? SLOW_M1 : FAST_M1;
    // >= rather than == so a shrinking limit fires at once instead of wrapping
    tick    = (cnt_q >= lim_m1);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    sync1_d = push;
    sync2_d = sync1_q;
    q1_d    = tick ? sync2_q : q1_q;
    q2_d    = tick ? q1_q : q2_q;
    // btn is the pair being latched on this tick; only meaningful with tick
    btn     = q1_d & q2_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      q1_q    <= '0;
      q2_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      q1_q    <= q1_d;
      q2_q    <= q2_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_pixel_gen.sv
// ============================================================================
// sprite_pixel_gen : movable box pixel generator. Buttons step the box once per
//                    tick; SPRITE_WRAP_EN selects wrap instead of clamp at edges.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_pixel_gen
  import vga_pkg::*;
#(
  parameter int         SCREEN_W  = 640,
  parameter int         SCREEN_H  = 480,
  parameter int         COORD_W   = 10,
  parameter int         BOX_W     = 40,
  parameter int         BOX_H     = 40,
  parameter int         STEP      = 10,
  parameter int         TICK_FAST = 250000,
  parameter int         TICK_SLOW = 1000000,
  parameter logic [2:0] FG_COLOR  = GREEN,
  parameter logic [2:0] BG_COLOR  = BLUE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               switch,
  input  logic [3:0]         push,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_on,
  output logic [2:0]         rgb,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y
);

`ifdef SPRITE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(SCREEN_W - BOX_W);
  localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(SCREEN_H - BOX_H);
  localparam logic [COORD_W-1:0] X_RST   = COORD_W'((SCREEN_W - BOX_W) / 2);
  localparam logic [COORD_W-1:0] Y_RST   = COORD_W'((SCREEN_H - BOX_H) / 2);
  localparam logic [COORD_W:0]   MAX_X_E = (COORD_W+1)'(SCREEN_W - BOX_W);
  localparam logic [COORD_W:0]   MAX_Y_E = (COORD_W+1)'(SCREEN_H - BOX_H);
  localparam logic [COORD_W:0]   STEP_E  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   BOX_W_E = (COORD_W+1)'(BOX_W);
  localparam logic [COORD_W:0]   BOX_H_E = (COORD_W+1)'(BOX_H);

  logic               tick;
  logic [3:0]         btn;
  move_e              mv;
  logic [COORD_W:0]   x_ext, y_ext;
  logic [COORD_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic [2:0]         rgb_q, rgb_d;
  logic               hit;

  btn_tick_debounce #(
    .TICK_FAST (TICK_FAST),
    .TICK_SLOW (TICK_SLOW),
    .NBTN      (4)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .switch (switch),
    .push   (push),
    .tick   (tick),
    .btn    (btn)
  );

  always_comb begin
    mv = MV_NONE;
    if (tick) begin
      if      (btn[BTN_UP])    mv = MV_UP;
      else if (btn[BTN_DOWN])  mv = MV_DOWN;
      else if (btn[BTN_LEFT])  mv = MV_LEFT;
      else if (btn[BTN_RIGHT]) mv = MV_RIGHT;
    end
  end

  // One extra bit keeps x+STEP and x+BOX_W from wrapping through 2**COORD_W
  always_comb begin
    x_ext   = {1'b0, box_x_q};
    y_ext   = {1'b0, box_y_q};
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    case (mv)
      MV_UP:    box_y_d = (y_ext < STEP_E) ? (WRAP_EN ? MAX_Y_C : '0)
                                           : COORD_W'(y_ext - STEP_E);
      MV_DOWN:  box_y_d = (y_ext + STEP_E > MAX_Y_E) ? (WRAP_EN ? '0 : MAX_Y_C)
                                                     : COORD_W'(y_ext + STEP_E);
      MV_LEFT:  box_x_d = (x_ext < STEP_E) ? (WRAP_EN ? MAX_X_C : '0)
                                           : COORD_W'(x_ext - STEP_E);
      MV_RIGHT: box_x_d = (x_ext + STEP_E > MAX_X_E) ? (WRAP_EN ? '0 : MAX_X_C)
                                                     : COORD_W'(x_ext + STEP_E);
      default:  ;
    endcase
  end

  always_comb begin
    hit = (pixel_x >= box_x_q) && ({1'b0, pixel_x} < x_ext + BOX_W_E) &&
          (pixel_y >= box_y_q) && ({1'b0, pixel_y} < y_ext + BOX_H_E);
    if (!video_on) rgb_d = BLACK;
    else if (hit)  rgb_d = FG_COLOR;
    else           rgb_d = BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      box_x_q <= X_RST;
      box_y_q <= Y_RST;
      rgb_q   <= BLACK;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb   = rgb_q;
  assign box_x = box_x_q;
  assign box_y = box_y_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_pixel_gen.sv
// ============================================================================
// tb_sprite_pixel_gen : directed bench with a due-cycle scoreboard for
//                       sprite_pixel_gen (TICK_FAST=4, TICK_SLOW=16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_pixel_gen;

  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          switch = 1'b0;
  logic [3:0]    push = 4'b0;
  logic [CW-1:0] px = '0;
  logic [CW-1:0] py = '0;
  logic          vid = 1'b0;
  logic [2:0]    rgb;
  logic [CW-1:0] bx, by;

  sprite_pixel_gen #(
    .TICK_FAST (4),
    .TICK_SLOW (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .switch   (switch),
    .push     (push),
    .pixel_x  (px),
    .pixel_y  (py),
    .video_on (vid),
    .rgb      (rgb),
    .box_x    (bx),
    .box_y    (by)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kind;   // 0 rgb, 1 box_x, 2 box_y
    int    exp;
    int    due;
  } chk_t;

  chk_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference tick timing, used only to align stimulus with tick boundaries
  int   m_cnt;
  logic m_tick;
  assign m_tick = (m_cnt >= (switch ? 15 : 3));
  always @(posedge clk or posedge rst) begin
    if (rst)         m_cnt <= 0;
    else if (m_tick) m_cnt <= 0;
    else             m_cnt <= m_cnt + 1;
  end

  initial begin : monitor
    logic [CW-1:0] act, e;
    forever begin
      @(negedge clk);
      #1;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].due <= cyc) begin
          case (sbq[i].kind)
            0:       act = {7'b0, rgb};
            1:       act = bx;
            default: act = by;
          endcase
          e = sbq[i].exp[CW-1:0];
          checks++;
          if (act !== e) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", sbq[i].name, act, e);
          end
          sbq.delete(i);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic expect_now(input string name, input int kind, input int exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp; c.due = cyc;
    sbq.push_back(c);
  endtask

  task automatic scan(input int x, input int y, input logic v, input int exp,
                      input string name);
    chk_t c;
    px = CW'(x); py = CW'(y); vid = v;
    c.name = name; c.kind = 0; c.exp = exp; c.due = cyc + 1;
    sbq.push_back(c);
    @(negedge clk);
  endtask

  // returns at the negedge just after the n-th tick edge
  task automatic wait_ticks(input int n);
    repeat (n) begin
      while (!m_tick) @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    expect_now("rst_x", 1, 300);
    expect_now("rst_y", 2, 220);
    expect_now("rst_rgb", 0, 0);
    checks++;
    if (bx !== CW'(300)) begin
      errors++;
      $display("FAIL init_rst_x: got %0d, expected 300", bx);
    end
    checks++;
    if (by !== CW'(220)) begin
      errors++;
      $display("FAIL init_rst_y: got %0d, expected 220", by);
    end
    checks++;
    if (rgb !== 3'b000) begin
      errors++;
      $display("FAIL init_rst_rgb: got %0d, expected 0", rgb);
    end
    @(negedge clk);
    rst = 1'b0;

    scan(300, 220, 1'b1, 2, "hit_topleft");
    scan(299, 220, 1'b1, 1, "miss_left");
    scan(339, 259, 1'b1, 2, "hit_botright");
    scan(340, 220, 1'b1, 1, "miss_right");
    scan(300, 219, 1'b1, 1, "miss_above");
    scan(300, 220, 1'b0, 0, "blank");

    // right held: first tick samples, moves from the second tick on
    wait_ticks(1);
    push = 4'b0010;
    wait_ticks(1); expect_now("right_t1", 1, 300);
    wait_ticks(1); expect_now("right_t2", 1, 310);
    wait_ticks(3); expect_now("right_t5", 1, 340);

    // slow rate: 16 clk per tick
    switch = 1'b1;
    wait_ticks(1); expect_now("slow_t1", 1, 350);
    repeat (15) @(negedge clk);
    expect_now("slow_hold", 1, 350);
    @(negedge clk);
    expect_now("slow_t2", 1, 360);

    // drop to fast at count 10: immediate tick, then period 4
    repeat (10) @(negedge clk);
    expect_now("sw_before", 1, 360);
    switch = 1'b0;
    @(negedge clk);
    expect_now("sw_tick", 1, 370);
    repeat (3) @(negedge clk);
    expect_now("sw_hold", 1, 370);
    @(negedge clk);
    expect_now("sw_period4", 1, 380);
    push = 4'b0;
    wait_ticks(3); expect_now("release", 1, 380);

    // one-tick pulse does not move
    push = 4'b0010;
    wait_ticks(1);
    push = 4'b0;
    wait_ticks(3); expect_now("pulse", 1, 380);

    // up beats down
    push = 4'b1001;
    wait_ticks(4);
    expect_now("updown_y", 2, 190);
    expect_now("updown_x", 1, 380);
    push = 4'b0;
    wait_ticks(2);

    // down clamps at 440
    push = 4'b1000;
    wait_ticks(26); expect_now("down_reach", 2, 440);
    wait_ticks(4);  expect_now("down_clamp", 2, 440);
    push = 4'b0;
    wait_ticks(2);
    scan(419, 479, 1'b1, 2, "edge_botright");
    scan(420, 440, 1'b1, 1, "edge_right");
    scan(380, 440, 1'b1, 2, "edge_topleft");
    scan(379, 479, 1'b1, 1, "edge_left");
    scan(380, 439, 1'b1, 1, "edge_above");
    vid = 1'b0;

    // left to 0, then clamp or wrap
    push = 4'b0100;
    wait_ticks(39); expect_now("left_zero", 1, 0);
`ifdef SPRITE_WRAP_EN
    wait_ticks(1); expect_now("left_edge1", 1, 600);
    wait_ticks(1); expect_now("left_edge2", 1, 590);
`else
    wait_ticks(1); expect_now("left_edge1", 1, 0);
    wait_ticks(1); expect_now("left_edge2", 1, 0);
`endif
    push = 4'b0;
    wait_ticks(2);

    // up to 0, then clamp or wrap
    push = 4'b0001;
    wait_ticks(45); expect_now("up_zero", 2, 0);
`ifdef SPRITE_WRAP_EN
    wait_ticks(1); expect_now("up_edge", 2, 440);
`else
    wait_ticks(1); expect_now("up_edge", 2, 0);
`endif
    push = 4'b0;
    wait_ticks(2);

    // asynchronous reset mid-run with rgb non-zero
`ifdef SPRITE_WRAP_EN
    scan(0, 0, 1'b1, 1, "pre_rst_rgb");
`else
    scan(0, 0, 1'b1, 2, "pre_rst_rgb");
`endif
    @(negedge clk);
    rst = 1'b1;
    expect_now("arst_x", 1, 300);
    expect_now("arst_y", 2, 220);
    expect_now("arst_rgb", 0, 0);
    #1;
    checks++;
    if (bx !== CW'(300)) begin
      errors++;
      $display("FAIL async_rst_x: got %0d, expected 300", bx);
    end
    checks++;
    if (by !== CW'(220)) begin
      errors++;
      $display("FAIL async_rst_y: got %0d, expected 220", by);
    end
    checks++;
    if (rgb !== 3'b000) begin
      errors++;
      $display("FAIL async_rst_rgb: got %0d, expected 0", rgb);
    end
    @(negedge clk);
    rst = 1'b0;

    // hit compare in the move cycle uses the old position
    wait_ticks(1);
    push = 4'b0010;
    wait_ticks(1);
    while (!m_tick) @(negedge clk);
    scan(300, 220, 1'b1, 2, "pre_update");
    expect_now("moved_x", 1, 310);
    scan(300, 220, 1'b1, 1, "post_update");
    push = 4'b0;
    vid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
